// File: rtl/z80_bus_cycle_pkg.sv
// Shared definitions for the Z80 machine-cycle sequencer: cycle-type codes,
// FSM state encoding, strobe-vector bit positions and small decode helpers.
package z80_bus_cycle_pkg;

    // Core request types; codes 5..7 run as bus-idle NOP cycles.
    localparam logic [2:0] CYC_FETCH  = 3'd0;
    localparam logic [2:0] CYC_MEM_RD = 3'd1;
    localparam logic [2:0] CYC_MEM_WR = 3'd2;
    localparam logic [2:0] CYC_IO_RD  = 3'd3;
    localparam logic [2:0] CYC_IO_WR  = 3'd4;

    // One state per T-state kind; TWA is a forced IO wait, TW a WAIT_n wait.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TWA  = 3'd3,
        ST_TW   = 3'd4,
        ST_T3   = 3'd5,
        ST_T4   = 3'd6,
        ST_HOLD = 3'd7
    } state_e;

    // Bit positions inside the packed active-low strobe vector.
    localparam int STB_W    = 6;
    localparam int STB_M1   = 5;
    localparam int STB_MREQ = 4;
    localparam int STB_IORQ = 3;
    localparam int STB_RD   = 2;
    localparam int STB_WR   = 1;
    localparam int STB_RFSH = 0;
    localparam logic [STB_W-1:0] STB_IDLE = 6'b111111;

    // True in the last T-state of a cycle: T4 of a fetch, T3 of anything else.
    function automatic logic is_final(input state_e s, input logic [2:0] t);
        logic f;
        if (s == ST_T4) begin
            f = 1'b1;
        end else if (s == ST_T3) begin
            f = (t != CYC_FETCH);
        end else begin
            f = 1'b0;
        end
        return f;
    endfunction

    // Cycle types that capture D_in into cyc_rdata.
    function automatic logic is_read(input logic [2:0] t);
        return (t == CYC_FETCH) || (t == CYC_MEM_RD) || (t == CYC_IO_RD);
    endfunction

endpackage

// File: rtl/z80_bus_cycle_refresh_ctr.sv
// Refresh register R: the low REFRESH_W bits count up (wrapping) on each
// inc_i pulse, the remaining upper bits keep their value.
module z80_refresh_ctr #(
    parameter int REFRESH_W = 7
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       inc_i,
    output logic [7:0] r_o
);

    localparam logic [7:0] LOW_MASK = 8'((9'd1 << REFRESH_W) - 9'd1);

    logic [7:0] r_q;
    logic [7:0] r_d;
    logic [7:0] r_inc_s;

    assign r_inc_s = r_q + 8'd1;

    // Next R: merge incremented low bits with untouched upper bits.
    always_comb begin
        r_d = r_q;
        if (inc_i) begin
            r_d = (r_q & ~LOW_MASK) | (r_inc_s & LOW_MASK);
        end else begin
            r_d = r_q;
        end
    end

    // R register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_q <= 8'h00;
        end else begin
            r_q <= r_d;
        end
    end

    assign r_o = r_q;

endmodule

// File: rtl/z80_bus_cycle.sv
// Z80 machine-cycle sequencer: turns one core request into T-states on the
// external bus pins (one CLK per T-state), with WAIT_n stretching, forced IO
// waits and M1 refresh addressing. All pin outputs are registered and are
// decoded from the next state, so they line up with the state register.
// Optional feature: define Z80_BUSREQ_EN to honour BUSRQ_n with a HOLD state.
module z80_bus_cycle
    import z80_bus_cycle_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int IO_AUTO_WAITS = 1,
    parameter int REFRESH_W     = 7
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cyc_req,
    input  logic [2:0]        cyc_type,
    input  logic [ADDR_W-1:0] cyc_addr,
    input  logic [DATA_W-1:0] cyc_wdata,
    input  logic [7:0]        i_reg,
    output logic              cyc_ready,
    output logic              cyc_done,
    output logic [DATA_W-1:0] cyc_rdata,
    output logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D_in,
    output logic [DATA_W-1:0] D_out,
    output logic              D_oe,
    output logic              M1_n,
    output logic              MREQ_n,
    output logic              IORQ_n,
    output logic              RD_n,
    output logic              WR_n,
    output logic              RFSH_n,
    input  logic              WAIT_n,
    input  logic              BUSRQ_n,
    output logic              BUSACK,
    output logic              bus_oe
);

    // Index of the last forced IO wait; unused when IO_AUTO_WAITS is 0.
    localparam logic [1:0] LAST_TWA = 2'(IO_AUTO_WAITS - 1);

    state_e              state_q, state_d;
    logic [2:0]          type_q, type_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [STB_W-1:0]    stb_q, stb_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic                doe_q, doe_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                busack_q, busack_d;

    logic                bus_free_s;
    logic                seq_end_s;
    logic                capture_s;
    logic                r_inc_s;
    logic [7:0]          r_s;
    logic [ADDR_W-1:0]   rfsh_addr_s;

`ifdef Z80_BUSREQ_EN
    assign bus_free_s = BUSRQ_n;
    // A request is not taken while the bus is being handed over.
    assign cyc_ready  = ready_q & BUSRQ_n;
`else
    logic unused_busrq_s;
    assign unused_busrq_s = BUSRQ_n;
    assign bus_free_s     = 1'b1;
    assign cyc_ready      = ready_q;
`endif

    assign seq_end_s   = (state_q == ST_IDLE) || is_final(state_q, type_q);
    assign rfsh_addr_s = ADDR_W'({i_reg, r_s});
    assign r_inc_s     = (state_q == ST_T4);

    // Read data is sampled on the edge entering T3 so it is valid with cyc_done.
    assign capture_s = is_read(type_q) && (state_d == ST_T3) && (state_q != ST_T3);
    assign rdata_d   = capture_s ? D_in : rdata_q;

    z80_refresh_ctr #(
        .REFRESH_W (REFRESH_W)
    ) u_refresh_ctr (
        .clk_i   (CLK),
        .reset_i (RESET),
        .inc_i   (r_inc_s),
        .r_o     (r_s)
    );

    // Next-state logic and request latching.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wcnt_d  = wcnt_q;
        if (seq_end_s) begin
            if (!bus_free_s) begin
                state_d = ST_HOLD;
            end else if (cyc_req && ready_q) begin
                state_d = ST_T1;
                type_d  = cyc_type;
                addr_d  = cyc_addr;
                wdata_d = cyc_wdata;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_T1: begin
                    state_d = ST_T2;
                end
                ST_T2: begin
                    case (type_q)
                        CYC_FETCH, CYC_MEM_RD, CYC_MEM_WR: begin
                            state_d = WAIT_n ? ST_T3 : ST_TW;
                        end
                        CYC_IO_RD, CYC_IO_WR: begin
                            if (IO_AUTO_WAITS > 0) begin
                                state_d = ST_TWA;
                                wcnt_d  = 2'd0;
                            end else begin
                                state_d = WAIT_n ? ST_T3 : ST_TW;
                            end
                        end
                        default: begin
                            state_d = ST_T3;
                        end
                    endcase
                end
                ST_TWA: begin
                    if (wcnt_q == LAST_TWA) begin
                        state_d = WAIT_n ? ST_T3 : ST_TW;
                    end else begin
                        wcnt_d = wcnt_q + 2'd1;
                    end
                end
                ST_TW: begin
                    state_d = WAIT_n ? ST_T3 : ST_TW;
                end
                ST_T3: begin
                    state_d = ST_T4;
                end
                ST_HOLD: begin
                    state_d = bus_free_s ? ST_IDLE : ST_HOLD;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Pin decode for the state being entered, registered on the same edge.
    always_comb begin
        stb_d    = STB_IDLE;
        a_d      = a_q;
        doe_d    = 1'b0;
        busack_d = 1'b0;
        done_d   = is_final(state_d, type_d);
        ready_d  = done_d || (state_d == ST_IDLE);
        case (state_d)
            ST_T1, ST_T2, ST_TWA, ST_TW, ST_T3, ST_T4: begin
                a_d = addr_d;
                case (type_d)
                    CYC_FETCH: begin
                        if ((state_d == ST_T3) || (state_d == ST_T4)) begin
                            a_d             = rfsh_addr_s;
                            stb_d[STB_RFSH] = 1'b0;
                            stb_d[STB_MREQ] = (state_d == ST_T4);
                        end else begin
                            stb_d[STB_M1]   = 1'b0;
                            stb_d[STB_MREQ] = 1'b0;
                            stb_d[STB_RD]   = 1'b0;
                        end
                    end
                    CYC_MEM_RD: begin
                        stb_d[STB_MREQ] = 1'b0;
                        stb_d[STB_RD]   = 1'b0;
                    end
                    CYC_MEM_WR: begin
                        stb_d[STB_MREQ] = 1'b0;
                        stb_d[STB_WR]   = (state_d == ST_T1);
                        doe_d           = 1'b1;
                    end
                    CYC_IO_RD: begin
                        stb_d[STB_IORQ] = (state_d == ST_T1);
                        stb_d[STB_RD]   = (state_d == ST_T1);
                    end
                    CYC_IO_WR: begin
                        stb_d[STB_IORQ] = (state_d == ST_T1);
                        stb_d[STB_WR]   = (state_d == ST_T1);
                        doe_d           = 1'b1;
                    end
                    default: begin
                        stb_d = STB_IDLE;
                    end
                endcase
            end
            ST_HOLD: begin
                busack_d = 1'b1;
            end
            default: begin
                stb_d = STB_IDLE;
            end
        endcase
    end

    // FSM state and latched request fields.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            type_q  <= 3'd0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            wcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Registered pin outputs and captured read data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stb_q    <= STB_IDLE;
            a_q      <= {ADDR_W{1'b0}};
            doe_q    <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            busack_q <= 1'b0;
            rdata_q  <= {DATA_W{1'b0}};
        end else begin
            stb_q    <= stb_d;
            a_q      <= a_d;
            doe_q    <= doe_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            busack_q <= busack_d;
            rdata_q  <= rdata_d;
        end
    end

    assign A         = a_q;
    assign D_out     = wdata_q;
    assign D_oe      = doe_q;
    assign cyc_done  = done_q;
    assign cyc_rdata = rdata_q;
    assign M1_n      = stb_q[STB_M1];
    assign MREQ_n    = stb_q[STB_MREQ];
    assign IORQ_n    = stb_q[STB_IORQ];
    assign RD_n      = stb_q[STB_RD];
    assign WR_n      = stb_q[STB_WR];
    assign RFSH_n    = stb_q[STB_RFSH];
    assign BUSACK    = busack_q;
    assign bus_oe    = ~busack_q;

endmodule
